// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer
// Captures a full MATRIX_SIZE x MATRIX_SIZE result on operation_complete and
// streams it out row-major, one element per valid/ready transfer.
// Ports:
//   clock_signal, reset_signal        : clock, synchronous active-low reset
//   operation_complete                : capture strobe from the adder
//   matrix_result_input[r][c]         : result matrix from the adder
//   capture_ready                     : high in IDLE, next strobe is captured
//   element_valid/ready               : output beat handshake
//   element_data/row/col/last         : beat payload, last on [N-1][N-1]
//   stream_done                       : one-cycle pulse after the last transfer
//   overrun_error                     : sticky, strobe seen while busy
module matrix_result_serializer #(
  parameter int unsigned MATRIX_SIZE = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  localparam int unsigned IDX_WIDTH  = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
  input  logic                  clock_signal,
  input  logic                  reset_signal,
  input  logic                  operation_complete,
  input  logic [DATA_WIDTH-1:0] matrix_result_input [MATRIX_SIZE][MATRIX_SIZE],
  output logic                  capture_ready,
  output logic                  element_valid,
  input  logic                  element_ready,
  output logic [DATA_WIDTH-1:0] element_data,
  output logic [IDX_WIDTH-1:0]  element_row,
  output logic [IDX_WIDTH-1:0]  element_col,
  output logic                  element_last,
  output logic                  stream_done,
  output logic                  overrun_error
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(MATRIX_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q [MATRIX_SIZE][MATRIX_SIZE];
  logic [DATA_WIDTH-1:0] buf_d [MATRIX_SIZE][MATRIX_SIZE];
  logic                  capture_ready_q, capture_ready_d;
  logic                  element_valid_q, element_valid_d;
  logic [DATA_WIDTH-1:0] element_data_q, element_data_d;
  logic [IDX_WIDTH-1:0]  element_row_q, element_row_d;
  logic [IDX_WIDTH-1:0]  element_col_q, element_col_d;
  logic                  element_last_q, element_last_d;
  logic                  stream_done_q, stream_done_d;
  logic                  overrun_error_q, overrun_error_d;
  logic [IDX_WIDTH-1:0]  nxt_row, nxt_col;

  // Row-major successor of the current beat index
  always_comb begin
    nxt_row = element_row_q;
    nxt_col = element_col_q + IDX_WIDTH'(1);
    if (element_col_q == LAST_IDX) begin
      nxt_col = '0;
      nxt_row = element_row_q + IDX_WIDTH'(1);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    buf_d           = buf_q;
    capture_ready_d = capture_ready_q;
    element_valid_d = element_valid_q;
    element_data_d  = element_data_q;
    element_row_d   = element_row_q;
    element_col_d   = element_col_q;
    element_last_d  = element_last_q;
    stream_done_d   = 1'b0;
    overrun_error_d = overrun_error_q | (operation_complete && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        capture_ready_d = 1'b1;
        if (operation_complete) begin
          // Buffer and first beat load on the same edge, so the first beat
          // is taken straight from the input rather than from buf_q.
          buf_d           = matrix_result_input;
          element_data_d  = matrix_result_input[0][0];
          element_row_d   = '0;
          element_col_d   = '0;
          element_last_d  = (LAST_IDX == '0);
          element_valid_d = 1'b1;
          capture_ready_d = 1'b0;
          state_d         = STREAM;
        end
      end
      STREAM: begin
        if (element_valid_q && element_ready) begin
          if (element_last_q) begin
            element_valid_d = 1'b0;
            element_last_d  = 1'b0;
            stream_done_d   = 1'b1;
            state_d         = DONE;
          end else begin
            element_row_d  = nxt_row;
            element_col_d  = nxt_col;
            element_data_d = buf_q[nxt_row][nxt_col];
            element_last_d = (nxt_row == LAST_IDX) && (nxt_col == LAST_IDX);
          end
        end
      end
      DONE: begin
        capture_ready_d = 1'b1;
        state_d         = IDLE;
      end
      default: begin
        capture_ready_d = 1'b1;
        element_valid_d = 1'b0;
        element_last_d  = 1'b0;
        state_d         = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock_signal) begin
    if (!reset_signal) begin
      state_q         <= IDLE;
      buf_q           <= '{default: '0};
      capture_ready_q <= 1'b1;
      element_valid_q <= 1'b0;
      element_data_q  <= '0;
      element_row_q   <= '0;
      element_col_q   <= '0;
      element_last_q  <= 1'b0;
      stream_done_q   <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      buf_q           <= buf_d;
      capture_ready_q <= capture_ready_d;
      element_valid_q <= element_valid_d;
      element_data_q  <= element_data_d;
      element_row_q   <= element_row_d;
      element_col_q   <= element_col_d;
      element_last_q  <= element_last_d;
      stream_done_q   <= stream_done_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  assign capture_ready = capture_ready_q;
  assign element_valid = element_valid_q;
  assign element_data  = element_data_q;
  assign element_row   = element_row_q;
  assign element_col   = element_col_q;
  assign element_last  = element_last_q;
  assign stream_done   = stream_done_q;
  assign overrun_error = overrun_error_q;

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Scoreboard bench for matrix_result_serializer (4x4, 8-bit).
module tb_matrix_result_serializer;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] r;
    logic [IW-1:0] c;
    logic          l;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          op;
  logic [DW-1:0] mat [N][N];
  logic          capture_ready;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [IW-1:0] row;
  logic [IW-1:0] col;
  logic          last;
  logic          stream_done;
  logic          overrun;

  int    checks = 0;
  int    errors = 0;
  int    done_seen = 0;
  int    last_seen = 0;
  beat_t sb[$];

  // Hand-computed A+B with A[r][c]=4r+c+1, B[r][c]=2(r+c), row-major
  int exp_tbl [16] = '{1, 4, 7, 10, 7, 10, 13, 16, 13, 16, 19, 22, 19, 22, 25, 28};

  matrix_result_serializer #(.MATRIX_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clock_signal        (clk),
    .reset_signal        (rst_n),
    .operation_complete  (op),
    .matrix_result_input (mat),
    .capture_ready       (capture_ready),
    .element_valid       (valid),
    .element_ready       (ready),
    .element_data        (data),
    .element_row         (row),
    .element_col         (col),
    .element_last        (last),
    .stream_done         (stream_done),
    .overrun_error       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int kind);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = (kind == 0) ? DW'((4*r + c + 1) + 2*(r + c)) : 8'hFF;
  endtask

  task automatic push_exp(input int kind);
    beat_t b;
    for (int i = 0; i < 16; i++) begin
      b.d = (kind == 0) ? DW'(exp_tbl[i]) : 8'hFF;
      b.r = IW'(i / 4);
      b.c = IW'(i % 4);
      b.l = (i == 15);
      sb.push_back(b);
    end
  endtask

  // Capture one matrix and drain it; exp_n = cycles from capture to stream_done
  task automatic run_stream(input int kind, input int alt, input int pulse_at,
                            input int corrupt, input int exp_n);
    int n;
    load(kind);
    push_exp(kind);
    op = 1'b1;
    cycle();
    op = 1'b0;
    chk("cap_valid", int'(valid), 1);
    chk("cap_ready_low", int'(capture_ready), 0);
    if (corrupt != 0) load(1);
    ready = (alt != 0) ? 1'b0 : 1'b1;
    n = 0;
    while (n < 100) begin
      cycle();
      n++;
      op = (n == pulse_at);
      if (stream_done) break;
      if (alt != 0) ready = ~ready;
    end
    op = 1'b0;
    ready = 1'b1;
    chk("stream_len", n, exp_n);
    chk("done_ready_low", int'(capture_ready), 0);
    chk("done_valid_low", int'(valid), 0);
    cycle();
    chk("idle_ready", int'(capture_ready), 1);
    chk("done_pulse_width", int'(stream_done), 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  // Monitor: pops on every transfer, checks stall stability
  beat_t held;
  logic  prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    got = '{d: data, r: row, c: col, l: last};
    if (stream_done) done_seen++;
    if (valid && last) last_seen++;
    if (valid && prev_stall) begin
      checks++;
      if (got !== held) begin
        errors++;
        $display("FAIL stall_hold: got d=%0d r=%0d c=%0d l=%0d expected d=%0d r=%0d c=%0d l=%0d",
                 got.d, got.r, got.c, got.l, held.d, held.r, held.c, held.l);
      end
    end
    if (valid && ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got d=%0d r=%0d c=%0d expected no beat", got.d, got.r, got.c);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL beat: got d=%0d r=%0d c=%0d l=%0d expected d=%0d r=%0d c=%0d l=%0d",
                   got.d, got.r, got.c, got.l, e.d, e.r, e.c, e.l);
        end
      end
    end
    prev_stall = valid && !ready;
    held = got;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int l0;
    int n;
    rst_n = 1'b0;
    op    = 1'b0;
    ready = 1'b0;
    load(0);
    repeat (3) cycle();
    chk("rst_capture_ready", int'(capture_ready), 1);
    chk("rst_valid", int'(valid), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_row", int'(row), 0);
    chk("rst_col", int'(col), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_done", int'(stream_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    ready = 1'b1;
    cycle();

    // 1: full-rate stream
    run_stream(0, 0, 0, 0, 16);
    // 2: alternating ready
    run_stream(0, 1, 0, 0, 32);
    // 3: input changes after capture, then all-FF capture
    run_stream(0, 0, 0, 1, 16);
    run_stream(1, 0, 0, 0, 16);
    chk("no_overrun_yet", int'(overrun), 0);
    // 4: strobe during beat 5
    load(0);
    run_stream(0, 0, 5, 0, 16);
    chk("overrun_set", int'(overrun), 1);
    repeat (5) cycle();
    chk("overrun_sticky", int'(overrun), 1);

    // 5: reset during beat 7
    load(0);
    push_exp(0);
    op = 1'b1;
    cycle();
    op = 1'b0;
    ready = 1'b1;
    repeat (7) cycle();
    d0 = done_seen;
    l0 = last_seen;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    sb.delete();
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_capture_ready", int'(capture_ready), 1);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_last", int'(last), 0);
    repeat (3) cycle();
    chk("midrst_valid_idle", int'(valid), 0);
    chk("midrst_no_done", done_seen - d0, 0);
    chk("midrst_no_last", last_seen - l0, 0);
    run_stream(0, 0, 0, 0, 16);

    // 6: strobe held high, back-to-back streams
    load(0);
    push_exp(0);
    ready = 1'b1;
    op = 1'b1;
    cycle();
    for (int s = 0; s < 3; s++) begin
      n = 0;
      while (n < 100) begin
        cycle();
        n++;
        if (stream_done) break;
      end
      chk("b2b_len", n, 16);
      cycle();
      chk("gap_idle_valid", int'(valid), 0);
      chk("gap_idle_ready", int'(capture_ready), 1);
      if (s < 2) push_exp(0);
      else op = 1'b0;
      cycle();
      chk("b2b_restart_valid", int'(valid), (s < 2) ? 1 : 0);
    end
    chk("b2b_overrun", int'(overrun), 1);
    chk("b2b_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
